// File: rtl/zx_video_pkg.sv
// Shared definitions for the ZX Spectrum screen pipeline.
// - Screen geometry (pixel + attribute bytes) and video RAM address width.
// - RX FSM state encoding used by the UART receiver.
package zx_video_pkg;

    localparam int unsigned ZX_SCREEN_BYTES = 6912;
    localparam int unsigned ZX_PIXEL_BYTES  = 6144;
    localparam int unsigned ZX_ADDR_W       = 13;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver with input synchroniser.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   rx          - serial input, idle high, asynchronous to clk
//   rx_byte     - last received byte (valid while byte_valid is high)
//   byte_valid  - one-cycle pulse, byte received with a good stop bit
//   stop_err    - one-cycle pulse, stop bit sampled low (byte discarded)
//   line_idle   - FSM in IDLE and synchronised line high
module uart_rx_8n1 #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 230_400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err,
    output logic       line_idle
);
    import zx_video_pkg::*;

    localparam int unsigned CPB   = CLK_HZ / BAUD;
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CNT_W = $clog2(CPB + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_comb begin
        sync1_d   = rx;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit; a short glitch is dropped here.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;
    assign stop_err   = err_q;
    assign line_idle  = (state_q == IDLE) && sync2_q;

endmodule

// File: rtl/zx_uart_screen_loader.sv
// Loads a ZX Spectrum screen image received over UART 8N1 into the write
// port of the video RAM, one byte per address, wrapping after the last byte.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   rx          - UART serial input
//   wr_addr     - video RAM write address
//   wr_data     - video RAM write data
//   wr_en       - one-cycle write strobe
//   busy        - a frame is being received
//   frame_done  - pulse with the write of the last screen byte
//   frame_err   - sticky stop-bit error, cleared by the next frame's first byte
module zx_uart_screen_loader
    import zx_video_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned BAUD         = 230_400,
    parameter int unsigned SCREEN_BYTES = ZX_SCREEN_BYTES,
    parameter int unsigned IDLE_CYCLES  = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [ZX_ADDR_W-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 wr_en,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0]    IDLE_PRE  = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [ZX_ADDR_W-1:0] ADDR_LAST = ZX_ADDR_W'(SCREEN_BYTES - 1);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       stop_err;
    logic       line_idle;

    uart_rx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stop_err   (stop_err),
        .line_idle  (line_idle)
    );

    logic [ZX_ADDR_W-1:0] addr_q, addr_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [ZX_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 wr_en_q, wr_en_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;

    always_comb begin
        addr_d       = addr_q;
        idle_cnt_d   = idle_cnt_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;

        // busy falls the cycle after the frame_done pulse
        if (frame_done_q) begin
            busy_d = 1'b0;
        end

        // Idle counter saturates at IDLE_MAX, so resync fires once per idle period.
        // A start bit makes line_idle low, which wins over the threshold.
        if (!line_idle) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            if (idle_cnt_q == IDLE_PRE && addr_q != '0) begin
                addr_d = '0;
                busy_d = 1'b0;
            end
        end

        if (stop_err) begin
            frame_err_d = 1'b1;
        end

        if (byte_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_byte;
            if (addr_q == '0) begin
                busy_d      = 1'b1;
                frame_err_d = 1'b0;
            end
            if (addr_q == ADDR_LAST) begin
                frame_done_d = 1'b1;
                addr_d       = '0;
            end else begin
                addr_d = addr_q + ZX_ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            idle_cnt_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            idle_cnt_q   <= idle_cnt_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_zx_uart_screen_loader.sv
// Bench for zx_uart_screen_loader. Bit rate and screen size are scaled down
// (12 clocks per bit, 40-byte screen, 2000-cycle idle resync) to keep runs short.
`timescale 1ns/1ps
module tb_zx_uart_screen_loader;

    localparam int unsigned CLK_HZ = 1_200_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned SB     = 40;
    localparam int unsigned IDLE   = 2000;
    localparam real         BIT_NS = 120.0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx = 1'b1;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en, busy, frame_done, frame_err;

    always #5 clk = ~clk;

    zx_uart_screen_loader #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .SCREEN_BYTES (SB),
        .IDLE_CYCLES  (IDLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        logic        fd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   wr_seen = 0;
    int   fd_seen = 0;
    int   exp_addr = 0;

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wr_seen++;
            if (frame_done) fd_seen++;
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (wr_addr !== mon_e.addr || wr_data !== mon_e.data || frame_done !== mon_e.fd)
                    $display("FAIL write: got addr=%0d data=%02h fd=%b, expected addr=%0d data=%02h fd=%b",
                             wr_addr, wr_data, frame_done, mon_e.addr, mon_e.data, mon_e.fd);
                else
                    pass_cnt++;
            end
        end else if (rst_n && frame_done) begin
            fd_seen++;
            total_cnt++;
            $display("FAIL frame_done_no_write: got frame_done=1 with wr_en=0, expected 0");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        sb_q.delete();
        exp_addr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input real bit_ns);
        exp_t e;
        if (stop_ok) begin
            e.addr = 13'(exp_addr);
            e.data = d;
            e.fd   = (exp_addr == int'(SB) - 1);
            sb_q.push_back(e);
            exp_addr = (exp_addr + 1) % int'(SB);
        end
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = stop_ok;
        #(bit_ns);
        rx = 1'b1;
        if (!stop_ok) #(bit_ns * 2.0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL %s_drain: got %0d writes pending, expected 0", name, sb_q.size());
        else
            pass_cnt++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_err} !== 25'd0)
            $display("FAIL reset_hold: got en=%b addr=%0d data=%02h busy=%b fd=%b err=%b, expected all 0",
                     wr_en, wr_addr, wr_data, busy, frame_done, frame_err);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_err} !== 25'd0)
            $display("FAIL reset_release: got en=%b addr=%0d busy=%b, expected all 0", wr_en, wr_addr, busy);
        else pass_cnt++;
    endtask

    task automatic test_single_byte;
        int w0 = wr_seen;
        send_byte(8'hA5, 1'b1, BIT_NS);
        drain("single");
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL single_busy: got %b, expected 1", busy); else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL single_err: got %b, expected 0", frame_err); else pass_cnt++;
        total_cnt++;
        if (wr_seen - w0 != 1) $display("FAIL single_count: got %0d writes, expected 1", wr_seen - w0); else pass_cnt++;
    endtask

    task automatic test_full_frame;
        int w0, f0;
        do_reset();
        w0 = wr_seen;
        f0 = fd_seen;
        for (int n = 0; n < int'(SB); n++) send_byte(8'(n), 1'b1, BIT_NS);
        drain("frame");
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL frame_busy: got %b, expected 0", busy); else pass_cnt++;
        total_cnt++;
        if (fd_seen - f0 != 1) $display("FAIL frame_done_count: got %0d, expected 1", fd_seen - f0); else pass_cnt++;
        total_cnt++;
        if (wr_seen - w0 != int'(SB)) $display("FAIL frame_count: got %0d, expected %0d", wr_seen - w0, SB); else pass_cnt++;
        send_byte(8'hC3, 1'b1, BIT_NS);
        drain("frame_next");
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL frame_next_busy: got %b, expected 1", busy); else pass_cnt++;
    endtask

    task automatic test_frame_err;
        int w0, f0;
        do_reset();
        w0 = wr_seen;
        send_byte(8'h3C, 1'b0, BIT_NS);
        repeat (10) @(negedge clk);
        total_cnt++;
        if (frame_err !== 1'b1) $display("FAIL err_set: got %b, expected 1", frame_err); else pass_cnt++;
        total_cnt++;
        if (wr_seen != w0 || busy !== 1'b0)
            $display("FAIL err_nowrite: got writes=%0d busy=%b, expected writes=0 busy=0", wr_seen - w0, busy);
        else pass_cnt++;
        f0 = fd_seen;
        send_byte(8'h80, 1'b1, BIT_NS);
        drain("err_first");
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL err_clear: got %b, expected 0", frame_err); else pass_cnt++;
        for (int n = 1; n < 5; n++) send_byte(8'(n + 8'h80), 1'b1, BIT_NS);
        send_byte(8'h3C, 1'b0, BIT_NS);
        drain("err_mid");
        total_cnt++;
        if (frame_err !== 1'b1) $display("FAIL err_mid_set: got %b, expected 1", frame_err); else pass_cnt++;
        for (int n = 5; n < int'(SB); n++) send_byte(8'(n + 8'h80), 1'b1, BIT_NS);
        drain("err_rest");
        total_cnt++;
        if (fd_seen - f0 != 1 || frame_err !== 1'b1)
            $display("FAIL err_frame_end: got fd=%0d err=%b, expected fd=1 err=1", fd_seen - f0, frame_err);
        else pass_cnt++;
    endtask

    task automatic test_idle_resync;
        int f0;
        do_reset();
        f0 = fd_seen;
        for (int n = 0; n < 25; n++) send_byte(8'(8'h40 + n), 1'b1, BIT_NS);
        drain("idle");
        repeat (int'(IDLE) - 300) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL idle_before: got busy=%b, expected 1", busy); else pass_cnt++;
        repeat (400) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_after: got busy=%b, expected 0", busy); else pass_cnt++;
        total_cnt++;
        if (fd_seen != f0 || frame_err !== 1'b0)
            $display("FAIL idle_flags: got fd=%0d err=%b, expected fd=0 err=0", fd_seen - f0, frame_err);
        else pass_cnt++;
        exp_addr = 0;
        send_byte(8'h11, 1'b1, BIT_NS);
        drain("idle_next");
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL idle_next_busy: got %b, expected 1", busy); else pass_cnt++;
    endtask

    task automatic test_glitch;
        int w0;
        do_reset();
        send_byte(8'h01, 1'b1, BIT_NS);
        drain("glitch_pre");
        w0 = wr_seen;
        rx = 1'b0;
        #20;
        rx = 1'b1;
        repeat (100) @(negedge clk);
        total_cnt++;
        if (wr_seen != w0) $display("FAIL glitch_nowrite: got %0d writes, expected 0", wr_seen - w0); else pass_cnt++;
        send_byte(8'h42, 1'b1, BIT_NS);
        drain("glitch_post");
        total_cnt++;
        if (wr_seen - w0 != 1) $display("FAIL glitch_post_count: got %0d, expected 1", wr_seen - w0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_byte;
        logic [7:0] d;
        int w0;
        do_reset();
        send_byte(8'h99, 1'b1, BIT_NS);
        drain("midrst_pre");
        d = 8'h5A;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        rx = d[4];
        #(BIT_NS / 2.0);
        w0 = wr_seen;
        rst_n = 1'b0;
        rx = 1'b1;
        sb_q.delete();
        exp_addr = 0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({wr_en, wr_addr, busy, frame_done, frame_err} !== 17'd0)
            $display("FAIL midrst_outputs: got en=%b addr=%0d busy=%b, expected all 0", wr_en, wr_addr, busy);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        total_cnt++;
        if (wr_seen != w0) $display("FAIL midrst_nowrite: got %0d writes, expected 0", wr_seen - w0); else pass_cnt++;
        send_byte(8'h7E, 1'b1, BIT_NS);
        drain("midrst_post");
    endtask

    task automatic test_baud_tolerance;
        int w0, f0;
        do_reset();
        w0 = wr_seen;
        f0 = fd_seen;
        for (int i = 0; i < 256; i++)
            send_byte(8'(i), 1'b1, (i < 128) ? BIT_NS / 1.02 : BIT_NS * 1.02);
        drain("baud");
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL baud_err: got %b, expected 0", frame_err); else pass_cnt++;
        total_cnt++;
        if (wr_seen - w0 != 256) $display("FAIL baud_count: got %0d, expected 256", wr_seen - w0); else pass_cnt++;
        total_cnt++;
        if (fd_seen - f0 != 256 / int'(SB))
            $display("FAIL baud_frames: got %0d, expected %0d", fd_seen - f0, 256 / int'(SB));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_full_frame();
        test_frame_err();
        test_idle_resync();
        test_glitch();
        test_reset_mid_byte();
        test_baud_tolerance();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
